core_resp_model: RTL and testbench

- Behavioural responder for the core-side load/store/AMO request interface.
- Sits where the L1 cache would sit; it answers requests from the sequencer or stimulus path, so the sequencer and checkers can be brought up without the cache.
- Holds a small backing memory and executes loads, byte-masked stores, RISC-V AMOs and LR/SC.
- Returns one in-order response per accepted request after a fixed latency, and limits the number of outstanding requests.

---
 rtl/core_resp_model.sv | 226 ++++++++++++++++++++++
 tb/tb_core_resp_model.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_resp_model.sv
// core_resp_model: behavioural stand-in for the L1 on the core-side request
// interface. Small backing memory with loads, byte-masked stores, RISC-V AMOs
// and LR/SC. Answers every accepted request in order after RESP_LAT cycles,
// and caps the number of accepted-but-unanswered requests at MAX_OUTST.
module core_resp_model #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 256,
    parameter int RESP_LAT  = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [7:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              amo_i,
    input  logic              lr_i,
    input  logic              sc_i,
    input  logic [4:0]        amo_op_i,
    input  logic              amo_word_i,
    input  logic              stall_i,
    input  logic              inv_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // AMO function. Bit 64 flags a recognised funct5; bits 63:0 are the new value.
    // 32-bit AMOs are fed with their operands in the upper half so that add
    // wraps at 32 bits and signed/unsigned compares need no special casing.
    function automatic logic [64:0] amo_calc(input logic [4:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
        logic [63:0] r;
        logic        ok;
        r  = a;
        ok = 1'b1;
        case (op)
            5'b00001: r = b;
            5'b00000: r = a + b;
            5'b00100: r = a ^ b;
            5'b01100: r = a & b;
            5'b01000: r = a | b;
            5'b10000: r = ($signed(a) < $signed(b)) ? a : b;
            5'b10100: r = ($signed(a) > $signed(b)) ? a : b;
            5'b11000: r = (a < b) ? a : b;
            5'b11100: r = (a > b) ? a : b;
            default: begin
                r  = a;
                ok = 1'b0;
            end
        endcase
        return {ok, r};
    endfunction

    // Expand 8 byte enables into a 64-bit write mask.
    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        m = 64'd0;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    logic [63:0]      r_mem [MEM_WORDS];
    logic             r_pv  [RESP_LAT];
    logic [63:0]      r_pd  [RESP_LAT];
    logic [CNT_W-1:0] r_outst;
    logic             r_res_v;
    logic [IDX_W-1:0] r_res_idx;

    logic [IDX_W-1:0] w_idx;
    logic             w_half;
    logic [63:0]      w_old;
    logic [31:0]      w_old32;
    logic [63:0]      w_old_x;
    logic [63:0]      w_half_mask;
    logic [64:0]      w_amo_res;
    logic             w_res_hit;
    logic             w_retire;
    logic             w_gnt;
    logic             w_accept;
    logic [63:0]      w_wmask;
    logic [63:0]      w_wval;
    logic [63:0]      w_result;
    logic             w_set_res;
    logic             w_clr_res;
    logic             w_unused;

    // Address bits that do not select a word; upper bits alias by design.
    assign w_unused    = ^{addr_i[ADDR_W-1:3+IDX_W], addr_i[1:0]};

    assign w_idx       = addr_i[3 +: IDX_W];
    assign w_half      = addr_i[2];
    assign w_old       = r_mem[w_idx];
    assign w_old32     = w_half ? w_old[63:32] : w_old[31:0];
    assign w_old_x     = amo_word_i ? {{32{w_old32[31]}}, w_old32} : w_old;
    assign w_half_mask = w_half ? {32'hFFFF_FFFF, 32'h0000_0000}
                                : {32'h0000_0000, 32'hFFFF_FFFF};
    assign w_amo_res   = amo_word_i ? amo_calc(amo_op_i, {w_old32, 32'h0000_0000},
                                               {wdata_i[31:0], 32'h0000_0000})
                                    : amo_calc(amo_op_i, w_old, wdata_i);
    assign w_res_hit   = r_res_v && (r_res_idx == w_idx);
    assign w_retire    = r_pv[RESP_LAT-1];
    assign w_accept    = req_i && w_gnt;

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_pv[RESP_LAT-1];
    assign rdata_o     = r_pd[RESP_LAT-1];

    // Grant: open unless stalled/reset or the outstanding limit is reached without a retire.
    always_comb begin
        w_gnt = 1'b0;
        if (rst_n && !stall_i) begin
            w_gnt = (r_outst < CNT_W'(MAX_OUTST)) || w_retire;
        end else begin
            w_gnt = 1'b0;
        end
    end

    // Decode the operation (sc > lr > amo > we > load) into write mask/value, result and reservation action.
    always_comb begin
        w_wmask   = 64'd0;
        w_wval    = wdata_i;
        w_result  = w_old;
        w_set_res = 1'b0;
        w_clr_res = 1'b0;
        if (sc_i) begin
            w_clr_res = 1'b1;
            if (w_res_hit) begin
                w_result = 64'd0;
                if (amo_word_i) begin
                    w_wmask = w_half_mask;
                    w_wval  = {wdata_i[31:0], wdata_i[31:0]};
                end else begin
                    w_wmask = be_mask(be_i);
                    w_wval  = wdata_i;
                end
            end else begin
                w_result = 64'd1;
            end
        end else if (lr_i) begin
            w_result  = w_old_x;
            w_set_res = 1'b1;
        end else if (amo_i) begin
            w_result  = w_old_x;
            w_clr_res = w_res_hit;
            if (w_amo_res[64]) begin
                if (amo_word_i) begin
                    w_wmask = w_half_mask;
                    w_wval  = {w_amo_res[63:32], w_amo_res[63:32]};
                end else begin
                    w_wmask = 64'hFFFF_FFFF_FFFF_FFFF;
                    w_wval  = w_amo_res[63:0];
                end
            end else begin
                w_wmask = 64'd0;
            end
        end else if (we_i) begin
            w_result  = 64'd0;
            w_wmask   = be_mask(be_i);
            w_wval    = wdata_i;
            w_clr_res = w_res_hit;
        end else begin
            w_result = w_old;
        end
    end

    // Backing memory: merge masked write data at the accepting edge (not reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_idx] <= (w_old & ~w_wmask) | (w_wval & w_wmask);
        end
    end

    // Reservation: LR sets it (wins over a snoop), SC/snoop/hitting store or AMO clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_v   <= 1'b0;
            r_res_idx <= '0;
        end else if (w_accept && w_set_res) begin
            r_res_v   <= 1'b1;
            r_res_idx <= w_idx;
        end else if (inv_i || (w_accept && w_clr_res)) begin
            r_res_v   <= 1'b0;
        end
    end

    // Response pipeline: fixed RESP_LAT delay; idle slots carry zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 64'd0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= w_accept ? w_result : 64'd0;
            for (int i = 1; i < RESP_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Outstanding counter: +1 on accept, -1 on response, unchanged when both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   r_outst <= r_outst - CNT_W'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

endmodule

// File: tb/tb_core_resp_model.sv
// Testbench for core_resp_model: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_core_resp_model;

    localparam int LAT  = 2;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n, req_i, we_i, amo_i, lr_i, sc_i, amo_word_i, stall_i, inv_i;
    logic [7:0]  be_i;
    logic [63:0] addr_i, wdata_i;
    logic [4:0]  amo_op_i;
    logic        gnt_o, rvalid_o;
    logic [63:0] rdata_o;

    always #5 clk = ~clk;

    core_resp_model #(.ADDR_W(64), .DATA_W(64), .MEM_WORDS(256),
                      .RESP_LAT(LAT), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .amo_i(amo_i), .lr_i(lr_i),
        .sc_i(sc_i), .amo_op_i(amo_op_i), .amo_word_i(amo_word_i),
        .stall_i(stall_i), .inv_i(inv_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o)
    );

    typedef struct { int due; logic [63:0] data; } resp_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc_n  = 0;
    int          gnt_cnt;
    resp_t       q[$];
    logic [63:0] obs[$];
    logic [63:0] mem [256];
    bit          res_v;
    int          res_idx;
    logic [4:0]  op_tab [10] = '{5'h01, 5'h00, 5'h04, 5'h0C, 5'h08,
                                 5'h10, 5'h14, 5'h18, 5'h1C, 5'h02};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference AMO: in word mode a/b hold 32-bit values in their low half.
    function automatic logic [63:0] amo_f(input logic [4:0] op, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input bit w, output bit ok);
        logic [63:0] a, b;
        longint sa, sb;
        a  = w ? {32'd0, a_in[31:0]} : a_in;
        b  = w ? {32'd0, b_in[31:0]} : b_in;
        sa = w ? longint'(sext32(a[31:0])) : longint'(a);
        sb = w ? longint'(sext32(b[31:0])) : longint'(b);
        ok = 1'b1;
        case (op)
            5'h01: return b;
            5'h00: return a + b;
            5'h04: return a ^ b;
            5'h0C: return a & b;
            5'h08: return a | b;
            5'h10: return (sa < sb) ? a : b;
            5'h14: return (sa > sb) ? a : b;
            5'h18: return (a < b) ? a : b;
            5'h1C: return (a > b) ? a : b;
            default: begin ok = 1'b0; return a; end
        endcase
    endfunction

    task automatic put_half(input int idx, input bit hi, input logic [31:0] v);
        if (hi) mem[idx][63:32] = v;
        else    mem[idx][31:0]  = v;
    endtask

    task automatic put_bytes(input int idx, input logic [7:0] be, input logic [63:0] wd);
        for (int b = 0; b < 8; b++)
            if (be[b]) mem[idx][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    // Execute the current request against the model and queue its response.
    task automatic model_accept();
        int idx; bit hi, hit, ok;
        logic [63:0] old, oldx, res, nv;
        logic [31:0] o32;
        idx  = int'(addr_i[10:3]);
        hi   = addr_i[2];
        old  = mem[idx];
        o32  = hi ? old[63:32] : old[31:0];
        oldx = amo_word_i ? sext32(o32) : old;
        hit  = res_v && (res_idx == idx);
        if (sc_i) begin
            if (hit) begin
                if (amo_word_i) put_half(idx, hi, wdata_i[31:0]);
                else            put_bytes(idx, be_i, wdata_i);
                res = 64'd0;
            end else res = 64'd1;
            res_v = 1'b0;
        end else if (lr_i) begin
            res = oldx; res_v = 1'b1; res_idx = idx;
        end else if (amo_i) begin
            nv = amo_f(amo_op_i, amo_word_i ? {32'd0, o32} : old, wdata_i, amo_word_i, ok);
            if (ok) begin
                if (amo_word_i) put_half(idx, hi, nv[31:0]);
                else            mem[idx] = nv;
            end
            res = oldx;
            if (hit) res_v = 1'b0;
        end else if (we_i) begin
            put_bytes(idx, be_i, wdata_i);
            res = 64'd0;
            if (hit) res_v = 1'b0;
        end else res = old;
        q.push_back('{cyc_n + LAT, res});
    endtask

    // One cycle: called just after a negedge with inputs set; checks and advances the model.
    task automatic tick();
        bit exp_rv, exp_gnt; logic [63:0] exp_rd; int outst;
        #1;
        outst   = q.size();
        exp_rv  = (outst > 0) && (q[0].due == cyc_n);
        exp_rd  = exp_rv ? q[0].data : 64'd0;
        exp_gnt = rst_n && !stall_i && ((outst < MAXO) || exp_rv);
        check("rvalid", {63'd0, rvalid_o}, {63'd0, exp_rv});
        check("rdata",  rdata_o, exp_rd);
        check("gnt",    {63'd0, gnt_o}, {63'd0, exp_gnt});
        if (rvalid_o) obs.push_back(rdata_o);
        if (gnt_o) gnt_cnt++;
        if (exp_rv) void'(q.pop_front());
        if (!rst_n) begin
            q.delete(); res_v = 1'b0;
        end else begin
            if (req_i && exp_gnt) model_accept();
            if (inv_i && !(req_i && exp_gnt && lr_i && !sc_i)) res_v = 1'b0;
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic drive(input logic r, w, a, l, s, input logic [7:0] be,
                         input logic [63:0] ad, wd, input logic [4:0] op, input logic wrd);
        req_i = r; we_i = w; amo_i = a; lr_i = l; sc_i = s; be_i = be;
        addr_i = ad; wdata_i = wd; amo_op_i = op; amo_word_i = wrd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic st(input logic [63:0] ad, wd, input logic [7:0] be);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, be, ad, wd, 5'd0, 1'b0); tick();
    endtask
    task automatic ld(input logic [63:0] ad);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ad, 64'd0, 5'd0, 1'b0); tick();
    endtask
    task automatic amo(input logic [63:0] ad, wd, input logic [4:0] op, input logic wrd);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, ad, wd, op, wrd); tick();
    endtask
    task automatic lr(input logic [63:0] ad);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, ad, 64'd0, 5'd0, 1'b0); tick();
    endtask
    task automatic sc(input logic [63:0] ad, wd);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, ad, wd, 5'd0, 1'b0); tick();
    endtask

    initial begin
        logic [63:0] ad;
        int k;
        rst_n = 1'b0; stall_i = 1'b0; inv_i = 1'b0; res_v = 1'b0; res_idx = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle(1);                         // reset state: gnt/rvalid/rdata all zero
        rst_n = 1'b1;

        // Store then load
        obs.delete();
        st(64'h10, 64'h1122334455667788, 8'hFF); ld(64'h10); idle(3);
        check("plan1_count", 64'(obs.size()), 64'd2);
        check("plan1_st", obs[0], 64'd0);
        check("plan1_ld", obs[1], 64'h1122334455667788);

        // Byte-masked store
        obs.delete();
        st(64'h10, 64'd0, 8'hFF); st(64'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F); ld(64'h10); idle(3);
        check("plan2_ld", obs[2], 64'h00000000_BBBBBBBB);

        // AMOs
        obs.delete();
        st(64'h10, 64'h00000000_FFFFFFFF, 8'hFF); amo(64'h10, 64'd1, 5'b00000, 1'b1); ld(64'h10);
        st(64'h10, 64'd3, 8'hFF); amo(64'h10, 64'd5, 5'b11100, 1'b0); ld(64'h10); idle(3);
        check("plan3_addw", obs[1], 64'hFFFFFFFF_FFFFFFFF);
        check("plan3_ld0",  obs[2], 64'd0);
        check("plan3_maxu", obs[4], 64'd3);
        check("plan3_ld5",  obs[5], 64'd5);

        // LR/SC
        obs.delete();
        st(64'h20, 64'd0, 8'hFF); lr(64'h20); sc(64'h20, 64'd7); ld(64'h20);
        sc(64'h20, 64'd9); ld(64'h20); lr(64'h20);
        inv_i = 1'b1; idle(1); inv_i = 1'b0;
        sc(64'h20, 64'd11); ld(64'h20); idle(3);
        check("plan4_sc_ok",   obs[2], 64'd0);
        check("plan4_ld7",     obs[3], 64'd7);
        check("plan4_sc_fail", obs[4], 64'd1);
        check("plan4_nowr",    obs[5], 64'd7);
        check("plan4_sc_inv",  obs[7], 64'd1);
        check("plan4_ld_end",  obs[8], 64'd7);

        // Back-to-back requests, then stall while holding req
        gnt_cnt = 0;
        for (int i = 0; i < 8; i++) ld(64'h10);
        check("plan5_gnt_cnt", 64'(gnt_cnt), 64'd8);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) ld(64'h10);
        stall_i = 1'b0;
        idle(3);

        // Reset with two responses in flight
        ld(64'h20); ld(64'h20);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        obs.delete();
        idle(4);
        check("plan6_no_rv", 64'(obs.size()), 64'd0);
        ld(64'h20); ld(64'h20); ld(64'h20); idle(3);
        check("plan6_after", 64'(obs.size()), 64'd3);

        // Randomized traffic over words 0..7 with aliasing upper address bits
        for (int i = 0; i < 8; i++) st(64'(i * 8), {$urandom(), $urandom()}, 8'hFF);
        for (int i = 0; i < 800; i++) begin
            ad        = {$urandom(), $urandom()};
            ad[10:3]  = 8'($urandom_range(0, 7));
            k         = $urandom_range(0, 9);
            rst_n     = ($urandom_range(0, 99) != 0);
            stall_i   = ($urandom_range(0, 7) == 0);
            inv_i     = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, 8'($urandom()), ad,
                  {$urandom(), $urandom()}, op_tab[k],
                  (k == 9) ? 1'b0 : 1'($urandom_range(0, 1)));
            tick();
        end
        rst_n = 1'b1; stall_i = 1'b0; inv_i = 1'b0;
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
